memory_sp_req_ctrl: RTL and testbench

//  Request sequencer directly upstream of the single-port memory; drives its memory_if.dst via mem_port (src).

---
 rtl/memory_sp_req_ctrl_if.sv | 16 +
 rtl/memory_sp_req_ctrl.sv | 149 ++++++++++++++
 tb/tb_memory_sp_req_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_sp_req_ctrl_if.sv
// memory_if: single-port memory access bundle.
// The requester drives enable/wr_en/addr/write_data through the src modport.
// The memory returns read_data one cycle after an enabled read, through the dst modport.
interface memory_if #(
    parameter int  ADDR_W = 1,
    parameter type data_t = logic [1:0]
) ();
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    data_t             write_data;
    data_t             read_data;

    modport src (output enable, output wr_en, output addr, output write_data, input read_data);
    modport dst (input enable, input wr_en, input addr, input write_data, output read_data);
endinterface

// File: rtl/memory_sp_req_ctrl.sv
// memory_sp_req_ctrl: request sequencer in front of a single-port memory.
// Accepts valid/ready read/write requests and issues at most one access per cycle.
// Read data (1-cycle latency) is captured into a response FIFO with backpressure.
// Reads are only accepted while a FIFO slot is guaranteed, so no data is lost.
// Optional feature: define MEMORY_SP_REQ_CTRL_STATS_EN for saturating
// accepted-write/read counters; otherwise wr_count/rd_count are tied to zero.
module memory_sp_req_ctrl #(
    parameter int  DEPTH     = 2,
    parameter type data_t    = logic [1:0],
    parameter int  RSP_DEPTH = 2,
    parameter int  ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [$bits(data_t)-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$bits(data_t)-1:0] rsp_rdata,
    output logic                     addr_err,
    output logic                     idle,
    output logic [31:0]              wr_count,
    output logic [31:0]              rd_count,
    memory_if.src                    mem_port
);
    localparam int DW    = $bits(data_t);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RSP_DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    // Request-side state
    logic             rd_pend;   // a read was accepted last cycle
    logic             rd_oor;    // that read was out of range -> return zero

    // Response FIFO
    logic [DW-1:0]    fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_occ;
    logic             fifo_empty;

    logic             credit;
    logic             acc;
    logic             in_range;
    logic             push;
    logic             pop;
    logic [DW-1:0]    push_data;
    logic [CNT_W:0]   outstanding;

    // Request acceptance, credit check and memory command decode
    always_comb begin
        outstanding = {1'b0, fifo_occ} + (CNT_W + 1)'(rd_pend);
        credit      = outstanding < {1'b0, CNT_FULL};
        req_ready   = req_wr | credit;
        acc         = req_valid & req_ready;
        in_range    = {1'b0, req_addr} < DEPTH_X;
    end

    assign mem_port.enable     = acc & in_range;
    assign mem_port.wr_en      = req_wr;
    assign mem_port.addr       = req_addr;
    assign mem_port.write_data = req_wdata;

    // Response path: push the pending read, bypass the storage when the FIFO is empty
    always_comb begin
        fifo_empty = (fifo_occ == '0);
        push       = rd_pend;
        push_data  = rd_oor ? '0 : DW'(mem_port.read_data);
        rsp_valid  = ~fifo_empty | rd_pend;
        rsp_rdata  = fifo_empty ? push_data : fifo_mem[rd_ptr];
        pop        = rsp_valid & rsp_ready;
        idle       = ~rd_pend & fifo_empty;
    end

    // Track the read in flight and the sticky address error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_oor   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_pend <= acc & ~req_wr;
            rd_oor  <= acc & ~req_wr & ~in_range;
            if (acc && !in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; a bypassed push+pop on an empty FIFO
    // writes and immediately consumes the same slot, keeping the logic uniform
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_occ <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_occ <= fifo_occ + 1'b1;
            end else if (pop && !push) begin
                fifo_occ <= fifo_occ - 1'b1;
            end
        end
    end

    // FIFO data storage (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Credit accounting must make a push into a full FIFO unreachable
    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_occ == CNT_FULL));

`ifdef MEMORY_SP_REQ_CTRL_STATS_EN
    // Saturating counters of accepted in-range writes and reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (acc && in_range && req_wr && wr_count != '1) begin
                wr_count <= wr_count + 32'd1;
            end
            if (acc && in_range && !req_wr && rd_count != '1) begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`else
    assign wr_count = '0;
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_memory_sp_req_ctrl.sv
// tb_memory_sp_req_ctrl: self-checking bench for memory_sp_req_ctrl.
// A behavioural memory sits on the dst side of memory_if; a reference model
// (shadow memory + queue of expected responses) predicts every output.
// Expectations for wr_count/rd_count follow MEMORY_SP_REQ_CTRL_STATS_EN.
module tb_memory_sp_req_ctrl;
    localparam int DEPTH     = 2;
    localparam int RSP_DEPTH = 2;
    localparam int ADDR_W    = 2;   // wider than needed so out-of-range addresses exist
`ifdef MEMORY_SP_REQ_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_rdata;
    logic              addr_err;
    logic              idle;
    logic [31:0]       wr_count;
    logic [31:0]       rd_count;

    memory_if #(.ADDR_W(ADDR_W), .data_t(logic [1:0])) mif ();

    memory_sp_req_ctrl #(
        .DEPTH    (DEPTH),
        .data_t   (logic [1:0]),
        .RSP_DEPTH(RSP_DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .addr_err (addr_err),
        .idle     (idle),
        .wr_count (wr_count),
        .rd_count (rd_count),
        .mem_port (mif)
    );

    // Single-port memory with 1-cycle read latency
    logic [1:0] mem_arr [4];
    always @(posedge clk) begin
        if (mif.enable) begin
            if (mif.wr_en) mem_arr[mif.addr] <= mif.write_data;
            else           mif.read_data     <= mem_arr[mif.addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [1:0]  ref_mem [DEPTH];
    logic [1:0]  exp_q [$];
    bit          ref_err;
    int unsigned ref_wr;
    int unsigned ref_rd;

    int unsigned n_checks;
    int unsigned n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        ref_err = 1'b0;
        ref_wr  = 0;
        ref_rd  = 0;
    endtask

    // Drive one cycle of stimulus (called at posedge+1), check at negedge, advance model
    task automatic step(input logic v, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [1:0] d, input logic rr);
        bit exp_ready, acc, inr;
        req_valid = v;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        #4;
        exp_ready = wr || (exp_q.size() < RSP_DEPTH);
        acc       = v && exp_ready;
        inr       = (int'(a) < DEPTH);
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        check("mem_enable", {31'd0, mif.enable}, {31'd0, acc && inr});
        if (acc && inr) begin
            check("mem_wr_en", {31'd0, mif.wr_en}, {31'd0, wr});
            check("mem_addr", {30'd0, mif.addr}, {30'd0, a});
            if (wr) check("mem_wdata", {30'd0, mif.write_data}, {30'd0, d});
        end
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) check("rsp_rdata", {30'd0, rsp_rdata}, {30'd0, exp_q[0]});
        check("idle", {31'd0, idle}, {31'd0, exp_q.size() == 0});
        check("addr_err", {31'd0, addr_err}, {31'd0, ref_err});
        check("wr_count", wr_count, STATS ? ref_wr : 32'd0);
        check("rd_count", rd_count, STATS ? ref_rd : 32'd0);
        if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
        if (acc) begin
            if (!inr) ref_err = 1'b1;
            if (wr) begin
                if (inr) begin
                    ref_mem[a[0]] = d;
                    ref_wr++;
                end
            end else begin
                exp_q.push_back(inr ? ref_mem[a[0]] : 2'b00);
                if (inr) ref_rd++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset at posedge+1, check reset values, release one cycle later
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_mem_enable", {31'd0, mif.enable}, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) mem_arr[i] = 2'b00;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 2'b00;
        mif.read_data = 2'b00;
        model_clear();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: write then read the same address
        step(1, 1, 1, 2'b10, 1);
        step(1, 0, 1, 2'b00, 1);
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_rsp_rdata", {30'd0, rsp_rdata}, 32'd2);
        step(0, 0, 0, 2'b00, 1);
        check("t1_addr_err", {31'd0, addr_err}, 32'd0);

        // 2: backpressure with RSP_DEPTH=2; writes still flow; drain in order
        step(1, 1, 0, 2'b01, 0);
        step(1, 0, 0, 2'b00, 0);
        step(1, 0, 1, 2'b00, 0);
        step(1, 0, 0, 2'b00, 0);
        step(1, 1, 1, 2'b11, 0);
        step(1, 0, 1, 2'b00, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 2'b00, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 1);

        // 4: out-of-range read returns zero and sets the sticky error
        step(1, 0, 2'(DEPTH), 2'b00, 1);
        check("t4_rsp_rdata", {30'd0, rsp_rdata}, 32'd0);
        check("t4_addr_err", {31'd0, addr_err}, 32'd1);
        step(1, 1, 3, 2'b11, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 1);

        // 5: reset with one FIFO entry and a read in flight
        step(1, 0, 0, 2'b00, 0);
        step(1, 0, 1, 2'b00, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 1);

        // 6: counters after 5 writes + 3 reads from reset
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 2'(i % 2), 2'(i), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 2'(i % 2), 2'b00, 1);
        step(0, 0, 0, 2'b00, 1);
        check("t6_wr_count", wr_count, STATS ? 32'd5 : 32'd0);
        check("t6_rd_count", rd_count, STATS ? 32'd3 : 32'd0);

        // 3: random traffic with concurrent push/pop and backpressure
        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(2, 3))
                                             : ADDR_W'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra,
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
